// File: rtl/uart_transmitter_cfg.sv
// rtl/uart_transmitter_cfg.sv - FIFO-fed UART transmitter with runtime parity, stop length and break
// Frame timing is paced by s_tick; tx is registered from the next state so it changes on the state edge.
module uart_transmitter_cfg #(
   parameter int DBIT       = 8,
   parameter int OVERSAMPLE = 16,
   parameter int FIFO_AW    = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               s_tick,
   input  logic               wr_en,
   input  logic [DBIT-1:0]    din,
   input  logic [1:0]         parity_mode,
   input  logic [1:0]         stop_bits,
   input  logic               send_break,
   output logic               full,
   output logic               empty,
   output logic [FIFO_AW:0]   level,
   output logic               overflow,
   output logic               tx_busy,
   output logic               tx_done_tick,
   output logic               tx
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam int SW    = $clog2(2 * OVERSAMPLE) + 1;
   localparam int NW    = (DBIT > 1) ? $clog2(DBIT) : 1;

   localparam logic [SW-1:0]      S_BIT_LAST    = SW'(OVERSAMPLE - 1);
   localparam logic [SW-1:0]      S_STOP15_LAST = SW'((3 * OVERSAMPLE) / 2 - 1);
   localparam logic [SW-1:0]      S_STOP2_LAST  = SW'(2 * OVERSAMPLE - 1);
   localparam logic [NW-1:0]      N_LAST        = NW'(DBIT - 1);
   localparam logic [FIFO_AW:0]   COUNT_FULL    = (FIFO_AW + 1)'(DEPTH);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      BREAK  = 3'd5,
      MAB    = 3'd6
   } state_t;

   logic [DBIT-1:0]    mem_q [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [FIFO_AW:0]   count_q;
   logic               overflow_q;
   logic               push, pop;

   state_t             state_q, state_d;
   logic [SW-1:0]      s_q, s_d;
   logic [NW-1:0]      n_q, n_d;
   logic [DBIT-1:0]    shift_q, shift_d;
   logic [DBIT-1:0]    data_q, data_d;
   logic [1:0]         pmode_q, pmode_d;
   logic [1:0]         stop_q, stop_d;
   logic               tx_q, tx_d;
   logic               done_q, done_d;
   logic [SW-1:0]      stop_last;
   logic               parity_on;
   logic               parity_bit;

   assign full         = (count_q == COUNT_FULL);
   assign empty        = (count_q == '0);
   assign level        = count_q;
   assign overflow     = overflow_q;
   assign push         = wr_en && !full;
   assign tx_busy      = (state_q != IDLE);
   assign tx_done_tick = done_q;
   assign tx           = tx_q;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= wr_en && full;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Parity and stop length come from the values latched at pop, never the live inputs.
   always_comb begin
      parity_on  = (pmode_q == 2'b01) || (pmode_q == 2'b10);
      parity_bit = (pmode_q == 2'b10) ? ~^data_q : ^data_q;
      case (stop_q)
         2'b00:   stop_last = S_BIT_LAST;
         2'b01:   stop_last = S_STOP15_LAST;
         default: stop_last = S_STOP2_LAST;
      endcase
   end

   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      n_d     = n_q;
      shift_d = shift_q;
      data_d  = data_q;
      pmode_d = pmode_q;
      stop_d  = stop_q;
      done_d  = 1'b0;
      pop     = 1'b0;
      tx_d    = 1'b1;

      case (state_q)
         IDLE: begin
            if (send_break) begin
               state_d = BREAK;
            end else if (!empty) begin
               pop     = 1'b1;
               shift_d = mem_q[rd_ptr_q];
               data_d  = mem_q[rd_ptr_q];
               pmode_d = parity_mode;
               stop_d  = stop_bits;
               s_d     = '0;
               state_d = START;
            end
         end
         START: begin
            if (s_tick) begin
               if (s_q == S_BIT_LAST) begin
                  s_d     = '0;
                  n_d     = '0;
                  state_d = DATA;
               end else begin
                  s_d = s_q + 1'b1;
               end
            end
         end
         DATA: begin
            if (s_tick) begin
               if (s_q == S_BIT_LAST) begin
                  s_d     = '0;
                  shift_d = shift_q >> 1;
                  if (n_q == N_LAST) begin
                     state_d = parity_on ? PARITY : STOP;
                  end else begin
                     n_d = n_q + 1'b1;
                  end
               end else begin
                  s_d = s_q + 1'b1;
               end
            end
         end
         PARITY: begin
            if (s_tick) begin
               if (s_q == S_BIT_LAST) begin
                  s_d     = '0;
                  state_d = STOP;
               end else begin
                  s_d = s_q + 1'b1;
               end
            end
         end
         STOP: begin
            if (s_tick) begin
               if (s_q == stop_last) begin
                  s_d     = '0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  s_d = s_q + 1'b1;
               end
            end
         end
         BREAK: begin
            if (!send_break) begin
               s_d     = '0;
               state_d = MAB;
            end
         end
         MAB: begin
            if (s_tick) begin
               if (s_q == S_BIT_LAST) begin
                  s_d     = '0;
                  state_d = IDLE;
               end else begin
                  s_d = s_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      case (state_d)
         START, BREAK: tx_d = 1'b0;
         DATA:         tx_d = shift_d[0];
         PARITY:       tx_d = parity_bit;
         default:      tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         s_q     <= '0;
         n_q     <= '0;
         shift_q <= '0;
         data_q  <= '0;
         pmode_q <= 2'b00;
         stop_q  <= 2'b00;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         n_q     <= n_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         pmode_q <= pmode_d;
         stop_q  <= stop_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_uart_transmitter_cfg.sv
// tb/tb_uart_transmitter_cfg.sv - randomized self-checking bench for uart_transmitter_cfg
// The line is recorded once per s_tick and compared against frames built from the frame rules.
module tb_uart_transmitter_cfg;
   localparam int OS   = 16;
   localparam int DBIT = 8;

   logic       clk = 1'b0;
   logic       reset, s_tick, wr_en, send_break;
   logic [7:0] din;
   logic [1:0] parity_mode, stop_bits;
   logic       full, empty, overflow, tx_busy, tx_done_tick, tx;
   logic [2:0] level;

   int checks = 0;
   int errors = 0;
   bit tick_en = 1'b1;
   int tick_cnt;

   bit line_q[$];
   int done_q[$];
   bit exp_bits[$];
   int seg_len[$];
   bit seg_done[$];
   bit seg_gap[$];

   uart_transmitter_cfg #(.DBIT(DBIT), .OVERSAMPLE(OS), .FIFO_AW(2)) dut (
      .clk(clk), .reset(reset), .s_tick(s_tick), .wr_en(wr_en), .din(din),
      .parity_mode(parity_mode), .stop_bits(stop_bits), .send_break(send_break),
      .full(full), .empty(empty), .level(level), .overflow(overflow),
      .tx_busy(tx_busy), .tx_done_tick(tx_done_tick), .tx(tx)
   );

   always #5 clk = ~clk;

   initial begin
      s_tick   = 1'b0;
      tick_cnt = 0;
      forever begin
         @(posedge clk);
         #1;
         tick_cnt = (tick_cnt == 2) ? 0 : tick_cnt + 1;
         s_tick   = tick_en && (tick_cnt == 0);
      end
   end

   always @(negedge clk) begin
      if (s_tick) line_q.push_back(tx);
      if (tx_done_tick) done_q.push_back(line_q.size());
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clear_rec();
      line_q.delete(); done_q.delete(); exp_bits.delete();
      seg_len.delete(); seg_done.delete(); seg_gap.delete();
   endtask

   task automatic add_level(input bit v, input int n);
      repeat (n) exp_bits.push_back(v);
   endtask

   task automatic add_frame(input logic [7:0] w, input logic [1:0] pm, input logic [1:0] sb, input bit gap);
      int len0 = exp_bits.size();
      add_level(1'b0, OS);
      for (int i = 0; i < DBIT; i++) add_level(w[i], OS);
      if (pm == 2'b01) add_level(^w, OS);
      else if (pm == 2'b10) add_level(~^w, OS);
      add_level(1'b1, (sb == 2'b00) ? OS : (sb == 2'b01) ? (3 * OS) / 2 : 2 * OS);
      seg_len.push_back(exp_bits.size() - len0);
      seg_done.push_back(1'b1);
      seg_gap.push_back(gap);
   endtask

   task automatic add_break(input int n);
      add_level(1'b0, n);
      add_level(1'b1, OS);
      seg_len.push_back(n + OS);
      seg_done.push_back(1'b0);
      seg_gap.push_back(1'b1);
   endtask

   task automatic check_stream(input string name);
      int li = 0;
      int ei = 0;
      int di = 0;
      bit tail_ok = 1'b1;
      for (int s = 0; s < seg_len.size(); s++) begin
         int start;
         int bad_at = -1;
         if (seg_gap[s]) while (li < line_q.size() && line_q[li] == 1'b1) li++;
         start = li;
         for (int k = 0; k < seg_len[s]; k++) begin
            if ((li >= line_q.size() || line_q[li] !== exp_bits[ei]) && bad_at < 0) bad_at = k;
            li++; ei++;
         end
         checks++;
         if (bad_at >= 0) begin
            errors++;
            $display("FAIL %s seg%0d waveform: first wrong tick offset %0d (recorded %0d ticks, required %0d from %0d)",
                     name, s, bad_at, line_q.size(), seg_len[s], start);
         end
         if (seg_done[s]) begin
            int got = (di < done_q.size()) ? done_q[di] : -1;
            checks++;
            if (got != start + seg_len[s]) begin
               errors++;
               $display("FAIL %s seg%0d tx_done_tick: at tick %0d, required %0d", name, s, got, start + seg_len[s]);
            end
            di++;
         end
      end
      while (li < line_q.size()) begin
         if (line_q[li] !== 1'b1) tail_ok = 1'b0;
         li++;
      end
      checks++;
      if (!tail_ok) begin
         errors++;
         $display("FAIL %s idle_tail: line low after last expected frame", name);
      end
      checks++;
      if (done_q.size() != di) begin
         errors++;
         $display("FAIL %s done_count: %0d pulses, required %0d", name, done_q.size(), di);
      end
   endtask

   task automatic write_word(input logic [7:0] w);
      @(posedge clk); #1;
      din   = w;
      wr_en = 1'b1;
      @(posedge clk); #1;
      wr_en = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int limit);
      int n = 0;
      while ((tx_busy || !empty) && n < limit) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (n >= limit) begin
         errors++;
         $display("FAIL %s timeout: busy=%0b empty=%0b after %0d clks", name, tx_busy, empty, n);
      end
      repeat (OS * 6) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks += 5;
      if (tx !== 1'b1)      begin errors++; $display("FAIL reset_tx: got %0b required 1", tx); end
      if (empty !== 1'b1)   begin errors++; $display("FAIL reset_empty: got %0b required 1", empty); end
      if (full !== 1'b0)    begin errors++; $display("FAIL reset_full: got %0b required 0", full); end
      if (level !== 3'd0)   begin errors++; $display("FAIL reset_level: got %0d required 0", level); end
      if (tx_busy !== 1'b0 || tx_done_tick !== 1'b0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL reset_pulses: busy=%0b done=%0b ovf=%0b required 0", tx_busy, tx_done_tick, overflow);
      end
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (tx !== 1'b1 || tx_busy !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_idle: tx=%0b busy=%0b required 1/0", tx, tx_busy);
      end
   endtask

   task automatic test_basic();
      clear_rec();
      parity_mode = 2'b00; stop_bits = 2'b00;
      write_word(8'hA5);
      @(posedge clk); #1;
      checks++;
      if (empty !== 1'b1 || tx !== 1'b0 || tx_busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_pop: empty=%0b tx=%0b busy=%0b required 1/0/1", empty, tx, tx_busy);
      end
      wait_idle("basic", 4000);
      add_frame(8'hA5, 2'b00, 2'b00, 1'b1);
      check_stream("basic");
   endtask

   task automatic test_parity();
      clear_rec();
      stop_bits = 2'b00;
      parity_mode = 2'b01; write_word(8'h07); wait_idle("parity_even", 4000);
      parity_mode = 2'b10; write_word(8'h07); wait_idle("parity_odd", 4000);
      add_frame(8'h07, 2'b01, 2'b00, 1'b1);
      add_frame(8'h07, 2'b10, 2'b00, 1'b1);
      check_stream("parity");
   endtask

   task automatic test_stop();
      logic [7:0] w1, w2;
      clear_rec();
      w1 = 8'($urandom); w2 = 8'($urandom);
      parity_mode = 2'b00;
      stop_bits = 2'b01; write_word(w1); wait_idle("stop15", 4000);
      stop_bits = 2'b10; write_word(w2); wait_idle("stop2", 4000);
      add_frame(w1, 2'b00, 2'b01, 1'b1);
      add_frame(w2, 2'b00, 2'b10, 1'b1);
      check_stream("stop");
   endtask

   task automatic test_random();
      clear_rec();
      for (int i = 0; i < 6; i++) begin
         logic [7:0] w;
         logic [1:0] pm, sb;
         w = 8'($urandom); pm = 2'($urandom_range(0, 3)); sb = 2'($urandom_range(0, 3));
         parity_mode = pm; stop_bits = sb;
         write_word(w);
         @(posedge clk); #1;
         parity_mode = 2'($urandom); stop_bits = 2'($urandom);
         wait_idle("random", 4000);
         add_frame(w, pm, sb, 1'b1);
      end
      check_stream("random");
   endtask

   task automatic test_fifo();
      logic [7:0] w[5];
      clear_rec();
      parity_mode = 2'b00; stop_bits = 2'b00;
      for (int i = 0; i < 5; i++) w[i] = 8'($urandom);
      write_word(w[0]);
      @(posedge clk); #1;
      for (int i = 1; i < 5; i++) begin
         din = w[i]; wr_en = 1'b1;
         @(posedge clk); #1;
      end
      checks++;
      if (full !== 1'b1 || level !== 3'd4) begin
         errors++;
         $display("FAIL fifo_full: full=%0b level=%0d required 1/4", full, level);
      end
      din = 8'($urandom);
      @(posedge clk); #1;
      wr_en = 1'b0;
      checks++;
      if (overflow !== 1'b1 || level !== 3'd4) begin
         errors++;
         $display("FAIL fifo_overflow: overflow=%0b level=%0d required 1/4", overflow, level);
      end
      @(posedge clk); #1;
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL fifo_overflow_pulse: overflow=%0b required 0", overflow);
      end
      wait_idle("fifo", 12000);
      for (int i = 0; i < 5; i++) add_frame(w[i], 2'b00, 2'b00, 1'b1);
      check_stream("fifo");
      checks++;
      if (level !== 3'd0) begin
         errors++;
         $display("FAIL fifo_level_end: got %0d required 0", level);
      end
   endtask

   task automatic test_break();
      logic [7:0] w;
      int n = 0;
      clear_rec();
      w = 8'($urandom);
      parity_mode = 2'b00; stop_bits = 2'b00;
      @(posedge clk); #1;
      send_break = 1'b1; din = w; wr_en = 1'b1;
      @(posedge clk); #1;
      wr_en = 1'b0;
      while (n < 300) begin
         @(negedge clk);
         if (s_tick) n++;
      end
      send_break = 1'b0;
      wait_idle("break", 4000);
      add_break(300);
      add_frame(w, 2'b00, 2'b00, 1'b0);
      check_stream("break");
   endtask

   task automatic test_reset_mid();
      int n = 0;
      parity_mode = 2'b00; stop_bits = 2'b00;
      write_word(8'hF0);
      write_word(8'h3C);
      while (n < OS + 3 * OS + 8) begin
         @(negedge clk);
         if (s_tick) n++;
      end
      #2;
      checks++;
      if (tx !== 1'b0 || level !== 3'd1) begin
         errors++;
         $display("FAIL midreset_pre: tx=%0b level=%0d required 0/1", tx, level);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (tx !== 1'b1 || level !== 3'd0 || empty !== 1'b1 || tx_busy !== 1'b0) begin
         errors++;
         $display("FAIL midreset_async: tx=%0b level=%0d empty=%0b busy=%0b required 1/0/1/0",
                  tx, level, empty, tx_busy);
      end
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      clear_rec();
      repeat (OS * 3 * 12) @(posedge clk);
      #1;
      checks++;
      if (tx_busy !== 1'b0) begin
         errors++;
         $display("FAIL midreset_after: busy=%0b required 0", tx_busy);
      end
      check_stream("midreset");
   endtask

   initial begin
      reset = 1'b0; wr_en = 1'b0; din = '0; send_break = 1'b0;
      parity_mode = 2'b00; stop_bits = 2'b00;
      test_reset();
      test_basic();
      test_parity();
      test_stop();
      test_random();
      test_fifo();
      test_break();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
